// File: rtl/scalar_read_arbiter.sv
// rtl/scalar_read_arbiter.sv - round-robin arbiter sharing the scalar register read mux
module scalar_read_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [4:0]        sel,
    input  logic [N-1:0]      mux_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [N-1:0]      rd_data,
    output logic [IDW-1:0]    rd_id,
    output logic              rd_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] winner;
    logic           found;
    logic [4:0]     win_addr;
    logic [IDW-1:0] rr_next;

    // Round-robin search: first active request at or after the rr pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(rr) + i) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr) + i) % NREQ);
            end
        end
    end

    assign win_addr = addr[5*winner +: 5];

    // The winner just served drops to lowest priority on the next round.
    assign rr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    // Arbitration / read / response FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= '0;
            rd_err   <= 1'b0;
            rr       <= '0;
            id_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << winner;
                        sel   <= win_addr;
                        id_q  <= winner;
                        state <= READ;
                    end else begin
                        gnt <= '0;
                    end
                end
                READ: begin
                    // Indices 16..31 do not exist; the mux output is meaningless there.
                    gnt      <= '0;
                    rd_data  <= sel[4] ? '0 : mux_data;
                    rd_err   <= sel[4];
                    rd_id    <= id_q;
                    rd_valid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    gnt <= '0;
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rr       <= rr_next;
                        state    <= IDLE;
                    end
                end
                default: begin
                    gnt      <= '0;
                    rd_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_read_arbiter.sv
// tb/tb_scalar_read_arbiter.sv - scoreboard bench for scalar_read_arbiter
module tb_scalar_read_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [5*NREQ-1:0] addr = '0;
    logic [NREQ-1:0]   gnt;
    logic [4:0]        sel;
    logic [N-1:0]      mux_data;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic [N-1:0]      rd_data;
    logic [IDW-1:0]    rd_id;
    logic              rd_err;

    logic [N-1:0] regs [16];

    typedef struct packed {
        logic [N-1:0]   data;
        logic [IDW-1:0] id;
        logic           err;
    } rsp_t;

    rsp_t            rsp_q[$];
    logic [NREQ-1:0] gnt_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    int n_gnt = 0;

    scalar_read_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .sel      (sel),
        .mux_data (mux_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_id    (rd_id),
        .rd_err   (rd_err)
    );

    always #5 clk = ~clk;

    // Register file model: reg[i] = ~i; out-of-range selects present garbage 0xF.
    assign mux_data = sel[4] ? 4'hF : regs[sel[3:0]];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Response monitor: every accepted response is popped and compared.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rd_valid && rd_ready) begin
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got data=%0d id=%0d err=%0d expected none",
                         rd_data, rd_id, rd_err);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_data", int'(rd_data), int'(e.data));
                check("rsp_id", int'(rd_id), int'(e.id));
                check("rsp_err", int'(rd_err), int'(e.err));
                n_pop++;
            end
        end
    end

    // Grant monitor: every grant pulse must match the next queued expectation.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        if (!rst && gnt != '0) begin
            if (gnt_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL gnt_unexpected: got %b expected none", gnt);
            end else begin
                eg = gnt_q.pop_front();
                check("gnt_order", int'(gnt), int'(eg));
            end
            n_gnt++;
        end
    end

    task automatic wait_gnt(input int prev);
        int t = 0;
        while (n_gnt == prev && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (n_gnt == prev) timeout("wait_gnt");
    endtask

    task automatic wait_pop(input int target);
        int t = 0;
        while (n_pop < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (n_pop < target) timeout("wait_pop");
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!rd_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rd_valid) timeout("wait_valid");
    endtask

    task automatic do_read(input int i, input logic [4:0] a, input logic [N-1:0] d, input logic e);
        int g0;
        int p0;
        g0 = n_gnt;
        p0 = n_pop;
        gnt_q.push_back(NREQ'(1) << i);
        rsp_q.push_back({d, IDW'(i), e});
        @(posedge clk); #1;
        addr[5*i +: 5] = a;
        req[i] = 1'b1;
        wait_gnt(g0);
        @(posedge clk); #1;
        req[i] = 1'b0;
        wait_pop(p0 + 1);
    endtask

    initial begin
        int g0;
        int p0;
        for (int i = 0; i < 16; i++) regs[i] = ~4'(i);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_valid", int'(rd_valid), 0);
        check("rst_data", int'(rd_data), 0);
        check("rst_id", int'(rd_id), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read of reg5 by requester 0 with latency checks
        gnt_q.push_back(4'b0001);
        rsp_q.push_back({4'hA, 2'd0, 1'b0});
        p0 = n_pop;
        @(posedge clk); #1;
        addr[4:0] = 5'd5;
        req = 4'b0001;
        @(negedge clk);
        check("lat_no_gnt_yet", int'(gnt), 0);
        @(negedge clk);
        check("lat_gnt", int'(gnt), 1);
        check("lat_sel", int'(sel), 5);
        check("lat_valid_low", int'(rd_valid), 0);
        @(posedge clk); #1;
        req = 4'b0000;
        @(negedge clk);
        check("lat_valid", int'(rd_valid), 1);
        check("lat_data", int'(rd_data), 10);
        wait_pop(p0 + 1);

        // Out-of-range index from requester 1
        do_read(1, 5'd17, 4'h0, 1'b1);

        // Reset while a response for requester 2 is pending
        rd_ready = 1'b0;
        g0 = n_gnt;
        gnt_q.push_back(4'b0100);
        @(posedge clk); #1;
        addr[14:10] = 5'd3;
        req = 4'b0100;
        wait_gnt(g0);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_valid();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(rd_valid), 0);
        check("mid_rst_data", int'(rd_data), 0);
        check("mid_rst_sel", int'(sel), 0);
        check("mid_rst_err", int'(rd_err), 0);
        check("mid_rst_id", int'(rd_id), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_ready = 1'b1;

        // All four requesting: rr restarts at 0 and rotates 0,1,2,3,0
        addr = {5'd4, 5'd3, 5'd2, 5'd1};
        gnt_q.push_back(4'b0001); rsp_q.push_back({4'hE, 2'd0, 1'b0});
        gnt_q.push_back(4'b0010); rsp_q.push_back({4'hD, 2'd1, 1'b0});
        gnt_q.push_back(4'b0100); rsp_q.push_back({4'hC, 2'd2, 1'b0});
        gnt_q.push_back(4'b1000); rsp_q.push_back({4'hB, 2'd3, 1'b0});
        gnt_q.push_back(4'b0001); rsp_q.push_back({4'hE, 2'd0, 1'b0});
        g0 = n_gnt;
        p0 = n_pop;
        req = 4'b1111;
        begin
            int t = 0;
            while (n_gnt < g0 + 5 && t < 80) begin
                @(negedge clk);
                t++;
            end
            if (n_gnt < g0 + 5) timeout("rr_grants");
        end
        @(posedge clk); #1;
        req = 4'b0000;
        wait_pop(p0 + 5);

        // Stalled consumer: response held, request activity ignored
        rd_ready = 1'b0;
        g0 = n_gnt;
        p0 = n_pop;
        gnt_q.push_back(4'b0010);
        rsp_q.push_back({4'h9, 2'd1, 1'b0});
        @(posedge clk); #1;
        addr[9:5] = 5'd6;
        req = 4'b0010;
        wait_gnt(g0);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            req = 4'(c + 3);
            addr = 20'(c * 12345);
            @(negedge clk);
            check("stall_valid", int'(rd_valid), 1);
            check("stall_data", int'(rd_data), 9);
            check("stall_id", int'(rd_id), 1);
            check("stall_gnt", int'(gnt), 0);
        end
        @(posedge clk); #1;
        req = 4'b0000;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", int'(rd_valid), 0);
        wait_pop(p0 + 1);

        // Requester 2 withdraws while the arbiter is busy with requester 0
        rd_ready = 1'b0;
        g0 = n_gnt;
        p0 = n_pop;
        gnt_q.push_back(4'b0001);
        rsp_q.push_back({4'h8, 2'd0, 1'b0});
        @(posedge clk); #1;
        addr[4:0] = 5'd7;
        req = 4'b0001;
        wait_gnt(g0);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_valid();
        @(posedge clk); #1;
        addr[14:10] = 5'd9;
        req = 4'b0100;
        @(posedge clk); #1;
        req = 4'b0000;
        rd_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("withdrawn_gnt", int'(gnt), 0);
        end
        wait_pop(p0 + 1);

        check("rsp_q_empty", rsp_q.size(), 0);
        check("gnt_q_empty", gnt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
